// File: rtl/cmd_seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_seq_serializer
//  Description : FE-I4 command sequencer core. A host-written bit pattern in
//                local byte memory is shifted MSB-first onto CMD_DATA, one bit
//                per BIT_EN strobe, optionally repeated back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_seq_serializer #(
    parameter int unsigned BASEADDR  = 32'h0000,
    parameter int unsigned HIGHADDR  = 32'h1FFF,
    parameter int          ABUSWIDTH = 16,
    parameter int          MEM_BYTES = 2048
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic [ABUSWIDTH-1:0] BUS_ADD,
    input  logic [7:0]           BUS_DATA_IN,
    output logic [7:0]           BUS_DATA_OUT,
    input  logic                 BUS_RD,
    input  logic                 BUS_WR,
    input  logic                 BIT_EN,
    output logic                 CMD_DATA,
    output logic                 READY
);

    localparam int                   c_MEM_AW      = $clog2(MEM_BYTES);
    localparam logic [ABUSWIDTH:0]   c_BASE        = (ABUSWIDTH+1)'(BASEADDR);
    localparam logic [ABUSWIDTH-1:0] c_SPAN        = ABUSWIDTH'(HIGHADDR - BASEADDR);
    localparam logic [ABUSWIDTH-1:0] c_OFF_RESET   = ABUSWIDTH'(0);
    localparam logic [ABUSWIDTH-1:0] c_OFF_START   = ABUSWIDTH'(1);
    localparam logic [ABUSWIDTH-1:0] c_OFF_SIZE_LO = ABUSWIDTH'(3);
    localparam logic [ABUSWIDTH-1:0] c_OFF_SIZE_HI = ABUSWIDTH'(4);
    localparam logic [ABUSWIDTH-1:0] c_OFF_REP_LO  = ABUSWIDTH'(5);
    localparam logic [ABUSWIDTH-1:0] c_OFF_REP_HI  = ABUSWIDTH'(6);
    localparam logic [ABUSWIDTH-1:0] c_MEM_LO      = ABUSWIDTH'(8);
    localparam logic [ABUSWIDTH-1:0] c_MEM_HI      = ABUSWIDTH'(8 + MEM_BYTES);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [7:0]          r_mem [MEM_BYTES];
    logic [15:0]         r_size;
    logic [15:0]         r_repeat;
    logic [15:0]         r_size_lat;
    logic [15:0]         r_rep_lat;
    logic [15:0]         r_idx;
    logic [15:0]         r_rep_cnt;
    logic [0:0]          r_state;
    logic                r_cmd_data;
    logic [7:0]          r_rd_data;

    // Window decode: the extra borrow bit flags addresses below BASEADDR.
    logic [ABUSWIDTH:0]   w_diff;
    logic [ABUSWIDTH-1:0] w_local;
    logic                 w_in_win;
    logic                 w_wr;
    logic                 w_soft_rst;
    logic                 w_start;
    logic                 w_is_mem;
    logic [c_MEM_AW-1:0]  w_mem_addr;
    logic [c_MEM_AW-1:0]  w_bit_addr;
    logic [2:0]           w_bit_sel;
    logic                 w_pat_bit;
    logic                 w_last_bit;
    logic                 w_more_reps;

    assign w_diff     = {1'b0, BUS_ADD} - c_BASE;
    assign w_local    = w_diff[ABUSWIDTH-1:0];
    assign w_in_win   = ~w_diff[ABUSWIDTH] && (w_local <= c_SPAN);
    assign w_wr       = BUS_WR && w_in_win;
    assign w_soft_rst = w_wr && (w_local == c_OFF_RESET);
    assign w_start    = w_wr && (w_local == c_OFF_START);
    assign w_is_mem   = (w_local >= c_MEM_LO) && (w_local < c_MEM_HI);
    assign w_mem_addr = c_MEM_AW'(w_local - c_MEM_LO);

    // Pattern bit i lives in byte i/8, MSB first; oversize patterns wrap the
    // byte address modulo the memory depth.
    assign w_bit_addr  = r_idx[c_MEM_AW+2:3];
    assign w_bit_sel   = 3'd7 - r_idx[2:0];
    assign w_pat_bit   = r_mem[w_bit_addr][w_bit_sel];
    assign w_last_bit  = (r_idx == (r_size_lat - 16'd1));
    assign w_more_reps = (({1'b0, r_rep_cnt} + 17'd1) < {1'b0, r_rep_lat});

    assign READY        = (r_state == c_ST_IDLE);
    assign CMD_DATA     = r_cmd_data;
    assign BUS_DATA_OUT = r_rd_data;

    // Pattern memory: host writes only, contents survive every reset.
    always_ff @(posedge BUS_CLK) begin
        if (w_wr && w_is_mem) begin
            r_mem[w_mem_addr] <= BUS_DATA_IN;
        end
    end

    // SIZE / REPEAT configuration registers, cleared only by BUS_RST.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_size   <= 16'd0;
            r_repeat <= 16'd0;
        end else if (w_wr) begin
            case (w_local)
                c_OFF_SIZE_LO: r_size[7:0]    <= BUS_DATA_IN;
                c_OFF_SIZE_HI: r_size[15:8]   <= BUS_DATA_IN;
                c_OFF_REP_LO:  r_repeat[7:0]  <= BUS_DATA_IN;
                c_OFF_REP_HI:  r_repeat[15:8] <= BUS_DATA_IN;
                default: ;
            endcase
        end
    end

    // Registered bus read mux; out-of-window and unlisted offsets return 0.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_rd_data <= 8'd0;
        end else if (BUS_RD) begin
            if (!w_in_win) begin
                r_rd_data <= 8'd0;
            end else if (w_is_mem) begin
                r_rd_data <= r_mem[w_mem_addr];
            end else begin
                case (w_local)
                    c_OFF_START:   r_rd_data <= {7'd0, READY};
                    c_OFF_SIZE_LO: r_rd_data <= r_size[7:0];
                    c_OFF_SIZE_HI: r_rd_data <= r_size[15:8];
                    c_OFF_REP_LO:  r_rd_data <= r_repeat[7:0];
                    c_OFF_REP_HI:  r_rd_data <= r_repeat[15:8];
                    default:       r_rd_data <= 8'd0;
                endcase
            end
        end
    end

    // Sequencer FSM: soft/hard reset beats any same-cycle strobe.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || w_soft_rst) begin
            r_state    <= c_ST_IDLE;
            r_idx      <= 16'd0;
            r_rep_cnt  <= 16'd0;
            r_cmd_data <= 1'b0;
            if (BUS_RST) begin
                r_size_lat <= 16'd0;
                r_rep_lat  <= 16'd1;
            end
        end else if (r_state == c_ST_IDLE) begin
            // The last bit is held until the next strobe returns the line low.
            if (BIT_EN) begin
                r_cmd_data <= 1'b0;
            end
            if (w_start && (r_size != 16'd0)) begin
                r_state    <= c_ST_SEND;
                r_idx      <= 16'd0;
                r_rep_cnt  <= 16'd0;
                r_size_lat <= r_size;
                r_rep_lat  <= (r_repeat == 16'd0) ? 16'd1 : r_repeat;
            end
        end else begin
            if (BIT_EN) begin
                r_cmd_data <= w_pat_bit;
                if (w_last_bit) begin
                    r_idx <= 16'd0;
                    if (w_more_reps) begin
                        r_rep_cnt <= r_rep_cnt + 16'd1;
                    end else begin
                        r_rep_cnt <= 16'd0;
                        r_state   <= c_ST_IDLE;
                    end
                end else begin
                    r_idx <= r_idx + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_seq_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_seq_serializer
//  Description : Scoreboard bench for cmd_seq_serializer. Stimulus updates a
//                register/memory model and queues expected bits and read data;
//                a monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_seq_serializer;

    localparam int c_MEM = 2048;

    logic        clk = 1'b0;
    logic        bus_rst = 1'b1;
    logic [15:0] bus_add = 16'd0;
    logic [7:0]  bus_din = 8'd0;
    logic [7:0]  bus_dout;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic        bit_en = 1'b0;
    logic        cmd_data;
    logic        ready;

    cmd_seq_serializer #(
        .BASEADDR (32'h0000),
        .HIGHADDR (32'h1FFF),
        .ABUSWIDTH(16),
        .MEM_BYTES(c_MEM)
    ) dut (
        .BUS_CLK     (clk),
        .BUS_RST     (bus_rst),
        .BUS_ADD     (bus_add),
        .BUS_DATA_IN (bus_din),
        .BUS_DATA_OUT(bus_dout),
        .BUS_RD      (bus_rd),
        .BUS_WR      (bus_wr),
        .BIT_EN      (bit_en),
        .CMD_DATA    (cmd_data),
        .READY       (ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_mem [c_MEM];
    logic [15:0] m_size = 16'd0;
    logic [15:0] m_repeat = 16'd0;
    bit          exp_q[$];
    bit          new_q[$];
    logic [7:0]  rd_q[$];
    bit          exp_cmd = 1'b0;
    int          be_period = 0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Model of a host write, applied when the write is issued.
    function automatic void model_write(input int a, input int d);
        int reps;
        if (a == 0) begin
            exp_q.delete();
            new_q.delete();
        end else if (a == 1) begin
            if (exp_q.size() == 0 && m_size != 16'd0) begin
                reps = (m_repeat == 16'd0) ? 1 : int'(m_repeat);
                for (int r = 0; r < reps; r++)
                    for (int i = 0; i < int'(m_size); i++)
                        new_q.push_back(m_mem[(i / 8) % c_MEM][7 - (i % 8)]);
            end
        end else if (a == 3) m_size[7:0] = d[7:0];
        else if (a == 4) m_size[15:8] = d[7:0];
        else if (a == 5) m_repeat[7:0] = d[7:0];
        else if (a == 6) m_repeat[15:8] = d[7:0];
        else if (a >= 8 && a < 8 + c_MEM) m_mem[a - 8] = d[7:0];
    endfunction

    function automatic logic [7:0] model_read(input int a);
        if (a == 1) return {7'd0, exp_q.size() == 0};
        if (a == 3) return m_size[7:0];
        if (a == 4) return m_size[15:8];
        if (a == 5) return m_repeat[7:0];
        if (a == 6) return m_repeat[15:8];
        if (a >= 8 && a < 8 + c_MEM) return m_mem[a - 8];
        return 8'd0;
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        bus_add = a[15:0];
        bus_din = d[7:0];
        bus_wr  = 1'b1;
        model_write(a, d);
        @(negedge clk);
        bus_wr  = 1'b0;
    endtask

    task automatic rd(input int a);
        @(negedge clk);
        bus_add = a[15:0];
        bus_rd  = 1'b1;
        rd_q.push_back(model_read(a));
        @(negedge clk);
        bus_rd  = 1'b0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        bus_rst  = 1'b1;
        m_size   = 16'd0;
        m_repeat = 16'd0;
        exp_q.delete();
        new_q.delete();
        @(negedge clk);
        bus_rst  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL idle_timeout: %0d bits still pending after %0d cycles", exp_q.size(), budget);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic setup(input int size, input int rep, input int period);
        wr(3, size & 8'hFF);
        wr(4, size >> 8);
        wr(5, rep & 8'hFF);
        wr(6, rep >> 8);
        be_period = period;
    endtask

    // BIT_EN generator: one strobe every be_period cycles (0 = off).
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (be_period == 0) begin
                bit_en = 1'b0;
                cnt = 0;
            end else begin
                bit_en = (cnt == 0);
                cnt = (cnt + 1) % be_period;
            end
        end
    end

    // Monitor: compares outputs against the model one step after each edge.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (bus_rst) begin
                exp_q.delete();
                new_q.delete();
                exp_cmd = 1'b0;
                chk("rst_dout", {8'd0, bus_dout}, 16'd0);
            end else if (bus_wr && bus_add == 16'd0) begin
                exp_cmd = 1'b0;
            end else begin
                if (bit_en) exp_cmd = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
                while (new_q.size() > 0) exp_q.push_back(new_q.pop_front());
                if (bus_rd) begin
                    if (rd_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL rd_queue: read with no expectation queued");
                    end else begin
                        e = rd_q.pop_front();
                        chk("rd_data", {8'd0, bus_dout}, {8'd0, e});
                    end
                end
            end
            chk("cmd_data", 16'(cmd_data), 16'(exp_cmd));
            chk("ready", 16'(ready), 16'(exp_q.size() == 0));
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < c_MEM; i++) m_mem[i] = 8'd0;
        repeat (3) @(negedge clk);
        bus_rst = 1'b0;
        rd(3);
        rd(1);

        // T1: 11-bit pattern, strobe every 4 clocks
        wr(8, 8'h81); wr(9, 8'h7E); wr(10, 8'hA1);
        setup(11, 0, 4);
        wr(1, 0);
        wait_idle(200);

        // T2: LV1 repeated three times, back-to-back strobes
        wr(8, 8'hE8);
        setup(5, 3, 1);
        wr(1, 0);
        wait_idle(100);

        // T3: zero-length start is ignored
        setup(0, 0, 1);
        wr(1, 0);
        rd(1);
        repeat (5) @(negedge clk);

        // T4: soft reset in the middle of a long repeat
        wr(8, 8'hC3); wr(9, 8'h5A);
        setup(16, 100, 1);
        wr(1, 0);
        repeat (20) @(negedge clk);
        wr(0, 0);
        rd(3); rd(4); rd(5); rd(6); rd(1);

        // T5: second START during SEND must not restart
        wr(8, 8'hB1); wr(9, 8'h00);
        setup(9, 0, 2);
        wr(1, 0);
        repeat (4) @(negedge clk);
        wr(1, 0);
        rd(1);
        wait_idle(100);

        // T6: hard reset mid-send
        wr(8, 8'h5A); wr(9, 8'h3C);
        setup(16, 5, 1);
        wr(1, 0);
        repeat (10) @(negedge clk);
        hard_reset();
        rd(3); rd(4); rd(5); rd(6); rd(8); rd(9); rd(1);

        // Address boundaries: last memory byte, unlisted offsets
        wr(8 + c_MEM - 1, 8'h96);
        wr(2, 8'hFF); wr(7, 8'hFF); wr(8 + c_MEM, 8'hFF);
        rd(8 + c_MEM - 1); rd(2); rd(7); rd(8 + c_MEM); rd(0);

        // Randomized patterns, sizes, repeat counts and strobe spacing
        for (int it = 0; it < 40; it++) begin
            be_period = 0;
            for (int b = 0; b < 6; b++) wr(8 + b, $urandom_range(0, 255));
            setup($urandom_range(1, 40), $urandom_range(0, 3), $urandom_range(1, 3));
            wr(1, 0);
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: rd(1);
                    1: rd(3);
                    2: rd(5);
                    default: rd(8 + $urandom_range(0, 5));
                endcase
            end
            wait_idle(2000);
        end

        be_period = 0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
